genetic_fitness_eval: RTL and testbench
=======================================

GENETIC_FITNESS_EVAL -- requirements
Module: genetic_fitness_eval

Interface
REQ-001 SHALL have parameter ROW, default 2, meaning rows of 4-input LUT cells.
REQ-002 SHALL have parameter COL, default 2, meaning columns of LUT cells.
REQ-003 SHALL have parameter IN, default 4, range 1..4, meaning primary circuit inputs.
REQ-004 SHALL have parameter OUT, default 2, meaning circuit outputs.
REQ-005 SHALL have parameter LOAD_W, default 8, meaning serial load beat width.
REQ-006 SHALL define derived values:
- CW = ROW*COL*16 + $clog2(ROW*COL)*OUT, the chromosome width.
- NB = ceil(CW/LOAD_W), the beats per chromosome.
- FW = $clog2(OUT*2^IN+1), the fitness width.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-008 load_valid  input  1  chromosome beat valid.
REQ-009 load_data  input  LOAD_W  chromosome beat, LSB chunk first.
REQ-010 load_ready  output  1  block accepts a beat.
REQ-011 target  input  OUT*2^IN  expected truth table; bits [OUT*v +: OUT] are the expected outputs for input vector v.
REQ-012 start  input  1  evaluation request.
REQ-013 busy  output  1  evaluation in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 fitness  output  FW  count of matching output bits.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, EVAL and DONE.
REQ-017 load_ready SHALL be 1 in IDLE and LOAD, and 0 in EVAL and DONE.
REQ-018 A beat SHALL be accepted when load_valid && load_ready. Beat k SHALL write chromosome bits [k*LOAD_W +: LOAD_W]; bits above CW-1 of the last beat SHALL be discarded.
REQ-019 Accepting a beat in IDLE SHALL clear the loaded flag, reset the beat counter and move the FSM to LOAD. Acceptance of beat NB-1 SHALL set the loaded flag and return the FSM to IDLE.
REQ-020 Cell (i,j) truth table SHALL be chromosome[16*(COL*i+j) +: 16]. Output selectors SHALL occupy bits [CW-1 : ROW*COL*16]. Both SHALL feed the team's combinational LUT-grid evaluator.
REQ-021 start in IDLE with the loaded flag set SHALL capture target, clear the vector counter and the fitness accumulator, set busy and enter EVAL. start in any other case SHALL be ignored.
REQ-022 EVAL SHALL apply one registered input vector per cycle, v = 0 .. 2^IN-1. Comparison SHALL be pipelined one stage: the match count of vector v is added in the cycle after v is applied.
REQ-023 Per-vector match count SHALL equal OUT minus the popcount of (grid_out XOR expected); the accumulator SHALL not wrap.
REQ-024 Latency: done SHALL assert exactly 2^IN+1 cycles after the start-accept edge. In that same cycle fitness SHALL update, busy SHALL deassert and the FSM SHALL be in DONE; the FSM SHALL return to IDLE on the next cycle.
REQ-025 fitness SHALL hold its value until the next accepted start. The chromosome SHALL persist across evaluations until a new load begins.
REQ-026 load_valid during EVAL or DONE SHALL have no effect.

Reset
REQ-027 rst SHALL set the following: state IDLE, load_ready 1, busy 0, done 0, fitness 0, loaded flag 0, counters 0.
REQ-028 rst SHALL take priority over all other inputs. Reset mid-LOAD or mid-EVAL SHALL abort the operation with no done pulse.

Configuration
REQ-029 With macro FIRST_FAIL_EN defined, the block SHALL add outputs first_fail (IN bits) and first_fail_vld (1 bit). first_fail SHALL hold the lowest vector with any mismatch. first_fail_vld SHALL be 1 if any mismatch occurred. Both SHALL be valid with done and held like fitness, and both SHALL reset to 0. Without the macro, these ports and their logic SHALL be absent.

Verification (ROW=2, COL=2, IN=2, OUT=1, LOAD_W=8, CW=66, NB=9)
REQ-030 Bench SHALL load 9 beats of 8'h00, then start with target 4'b0000 -> done 5 cycles after start, fitness=4.
REQ-031 Bench SHALL re-start with the same chromosome and target 4'b1010 -> fitness=2; with FIRST_FAIL_EN, first_fail=1 and first_fail_vld=1.
REQ-032 Bench SHALL load all LUTs 16'hFFFF (beats 8'hFF), then start with target 4'b0000 -> fitness=0; with FIRST_FAIL_EN, first_fail=0.
REQ-033 Bench SHALL apply start after only 5 of 9 beats -> no busy and no done; load_ready stays 1.
REQ-034 Bench SHALL assert rst 2 cycles into EVAL -> busy=0, fitness=0, no done. A following start SHALL be ignored until a full reload.
REQ-035 Bench SHALL hold load_valid=1 throughout EVAL -> no beat accepted and the chromosome unchanged; re-evaluation SHALL give the same fitness.

Source files
------------

// File: rtl/genetic_fitness_eval_if.sv
// genetic_fitness_eval_if
//   Bundles the chromosome load stream, the evaluation request/status and the
//   fitness result of genetic_fitness_eval.
//   Parameters: IN (circuit inputs), OUT (circuit outputs), LOAD_W (beat width).
//   Signals:
//     load_valid / load_data / load_ready : serial chromosome load, LSB chunk first
//     target                              : expected truth table, OUT bits per vector
//     start / busy / done                 : evaluation request, in-progress, completion pulse
//     fitness                             : number of matching output bits
//     first_fail / first_fail_vld         : lowest mismatching vector (FIRST_FAIL_EN only)
//   Modports: master drives load/target/start, slave is the evaluator.
interface genetic_fitness_eval_if #(
    parameter int IN     = 4,
    parameter int OUT    = 2,
    parameter int LOAD_W = 8
);
    localparam int FW = $clog2(OUT * (2 ** IN) + 1);

    logic                    load_valid;
    logic [LOAD_W-1:0]       load_data;
    logic                    load_ready;
    logic [OUT*(2**IN)-1:0]  target;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [FW-1:0]           fitness;
`ifdef FIRST_FAIL_EN
    logic [IN-1:0]           first_fail;
    logic                    first_fail_vld;
`endif

    modport master (
        output load_valid, load_data, target, start,
        input  load_ready, busy, done, fitness
`ifdef FIRST_FAIL_EN
        , input first_fail, first_fail_vld
`endif
    );

    modport slave (
        input  load_valid, load_data, target, start,
        output load_ready, busy, done, fitness
`ifdef FIRST_FAIL_EN
        , output first_fail, first_fail_vld
`endif
    );
endinterface

// File: rtl/genetic_fitness_eval.sv
// genetic_fitness_eval
//   Loads a chromosome describing a ROW x COL grid of 4-input LUT cells plus
//   per-output cell selectors, then sweeps all 2^IN input vectors through the
//   grid and counts how many output bits match the target truth table.
//   Optional feature macro: FIRST_FAIL_EN adds first_fail/first_fail_vld.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : genetic_fitness_eval_if.slave (load stream, target, start/busy/done, fitness)
//   Chromosome layout: cell (i,j) LUT = chrom[16*(COL*i+j) +: 16];
//   output o selector = chrom[ROW*COL*16 + SW*o +: SW].
//   Grid wiring: column 0 sees the input vector zero-extended to 4 bits;
//   cell input k of column j>0 is the output of row (k mod ROW) in column j-1.
//   A selector value beyond the last cell yields a constant 0 output.
module genetic_fitness_eval #(
    parameter int ROW    = 2,
    parameter int COL    = 2,
    parameter int IN     = 4,
    parameter int OUT    = 2,
    parameter int LOAD_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    genetic_fitness_eval_if.slave bus
);
    localparam int NCELL = ROW * COL;
    localparam int SW    = $clog2(NCELL);
    localparam int NPAD  = 2 ** SW;
    localparam int CW    = NCELL * 16 + SW * OUT;
    localparam int NB    = (CW + LOAD_W - 1) / LOAD_W;
    localparam int NV    = 2 ** IN;
    localparam int FW    = $clog2(OUT * NV + 1);
    localparam int BCW   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       chrom_q, chrom_d;
    logic [BCW-1:0]      beat_q;
    logic                loaded_q;
    logic [OUT*NV-1:0]   tgt_q;
    logic [IN-1:0]       vec_q;
    logic                app_q;      // vectors still being applied
    logic                pv_q;       // pipeline stage holds a valid match count
    logic [FW-1:0]       pcnt_q;
    logic                pmis_q;
    logic [IN-1:0]       pvec_q;
    logic [FW-1:0]       acc_q;
    logic [FW-1:0]       fit_q;
    logic                ff_seen_q;
    logic [IN-1:0]       ff_vec_q;
`ifdef FIRST_FAIL_EN
    logic [IN-1:0]       ff_out_q;
    logic                ff_vld_out_q;
`endif

    logic                load_ready;
    logic                beat_acc;
    logic                last_beat;
    logic [BCW-1:0]      cur_beat;
    logic                start_acc;
    logic                eval_fin;
    logic [FW-1:0]       acc_sum;
    logic                ff_seen_n;
    logic [IN-1:0]       ff_vec_n;

    // ------------------------------------------------------------------
    // FSM: state register and next-state/output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_ready = (state_q == IDLE) || (state_q == LOAD);
        beat_acc   = bus.load_valid && load_ready;
        cur_beat   = (state_q == IDLE) ? '0 : beat_q;
        last_beat  = (cur_beat == BCW'(NB - 1));
        // A beat arriving in IDLE starts a reload and wins over start.
        start_acc  = (state_q == IDLE) && !beat_acc && bus.start && loaded_q;
        // Last accumulation happens once all vectors are applied and the
        // pipeline still holds the final count.
        eval_fin   = (state_q == EVAL) && !app_q && pv_q;
        unique case (state_q)
            IDLE: begin
                if (beat_acc)       state_d = last_beat ? IDLE : LOAD;
                else if (start_acc) state_d = EVAL;
            end
            LOAD: if (beat_acc && last_beat) state_d = IDLE;
            EVAL: if (eval_fin) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.busy       = (state_q == EVAL);
    assign bus.done       = (state_q == DONE);
    assign bus.fitness    = fit_q;
`ifdef FIRST_FAIL_EN
    assign bus.first_fail     = ff_out_q;
    assign bus.first_fail_vld = ff_vld_out_q;
`endif

    // ------------------------------------------------------------------
    // Chromosome beat write: bits beyond CW-1 of the last beat never land
    // ------------------------------------------------------------------
    for (genvar b = 0; b < CW; b++) begin : g_wr
        assign chrom_d[b] = (cur_beat == BCW'(b / LOAD_W)) ? bus.load_data[b % LOAD_W]
                                                           : chrom_q[b];
    end

    // ------------------------------------------------------------------
    // Combinational LUT grid
    // ------------------------------------------------------------------
    logic [3:0]        vec4;
    logic [NCELL-1:0]  cells;
    logic [NPAD-1:0]   cells_pad;
    logic [OUT-1:0]    grid_out;

    always_comb begin
        vec4          = '0;
        vec4[IN-1:0]  = vec_q;
    end

    for (genvar j = 0; j < COL; j++) begin : g_col
        logic [ROW-1:0] co;
        for (genvar i = 0; i < ROW; i++) begin : g_row
            logic [3:0]  sel;
            logic [15:0] lut;
            if (j == 0) begin : g_first
                assign sel = vec4;
            end else begin : g_next
                for (genvar k = 0; k < 4; k++) begin : g_in
                    assign sel[k] = g_col[j-1].co[k % ROW];
                end
            end
            assign lut              = chrom_q[16*(COL*i+j) +: 16];
            assign co[i]            = lut[sel];
            assign cells[COL*i + j] = co[i];
        end
    end

    assign cells_pad = NPAD'(cells);

    for (genvar o = 0; o < OUT; o++) begin : g_out
        logic [SW-1:0] osel;
        assign osel        = chrom_q[NCELL*16 + SW*o +: SW];
        assign grid_out[o] = cells_pad[osel];
    end

    // ------------------------------------------------------------------
    // Per-vector match count
    // ------------------------------------------------------------------
    logic [OUT-1:0] exp_bits;
    logic [OUT-1:0] mis;
    logic [FW-1:0]  cnt;

    always_comb begin
        exp_bits = '0;
        for (int unsigned v = 0; v < NV; v++) begin
            if (vec_q == IN'(v)) exp_bits = tgt_q[OUT*v +: OUT];
        end
        mis = grid_out ^ exp_bits;
        cnt = FW'(OUT);
        for (int unsigned o = 0; o < OUT; o++) begin
            cnt = cnt - FW'(mis[o]);
        end
    end

    // acc never exceeds OUT*NV, which FW is sized to hold.
    assign acc_sum   = acc_q + pcnt_q;
    assign ff_seen_n = ff_seen_q | pmis_q;
    assign ff_vec_n  = (!ff_seen_q && pmis_q) ? pvec_q : ff_vec_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            chrom_q      <= '0;
            beat_q       <= '0;
            loaded_q     <= 1'b0;
            tgt_q        <= '0;
            vec_q        <= '0;
            app_q        <= 1'b0;
            pv_q         <= 1'b0;
            pcnt_q       <= '0;
            pmis_q       <= 1'b0;
            pvec_q       <= '0;
            acc_q        <= '0;
            fit_q        <= '0;
            ff_seen_q    <= 1'b0;
            ff_vec_q     <= '0;
`ifdef FIRST_FAIL_EN
            ff_out_q     <= '0;
            ff_vld_out_q <= 1'b0;
`endif
        end else begin
            if (beat_acc) begin
                chrom_q  <= chrom_d;
                loaded_q <= last_beat;
                beat_q   <= last_beat ? '0 : cur_beat + 1'b1;
            end

            if (start_acc) begin
                tgt_q     <= bus.target;
                vec_q     <= '0;
                app_q     <= 1'b1;
                pv_q      <= 1'b0;
                acc_q     <= '0;
                ff_seen_q <= 1'b0;
                ff_vec_q  <= '0;
            end

            if (state_q == EVAL) begin
                pv_q   <= app_q;
                pcnt_q <= cnt;
                pmis_q <= |mis;
                pvec_q <= vec_q;
                if (app_q) begin
                    vec_q <= vec_q + 1'b1;
                    if (vec_q == '1) app_q <= 1'b0;
                end
                if (pv_q) begin
                    acc_q     <= acc_sum;
                    ff_seen_q <= ff_seen_n;
                    ff_vec_q  <= ff_vec_n;
                end
                if (eval_fin) begin
                    fit_q        <= acc_sum;
`ifdef FIRST_FAIL_EN
                    ff_out_q     <= ff_vec_n;
                    ff_vld_out_q <= ff_seen_n;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_genetic_fitness_eval.sv
// tb_genetic_fitness_eval
//   Directed bench for genetic_fitness_eval with ROW=2, COL=2, IN=2, OUT=1,
//   LOAD_W=8 (CW=66, NB=9). Expected values are worked out by hand.
module tb_genetic_fitness_eval;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    genetic_fitness_eval_if #(.IN(2), .OUT(1), .LOAD_W(8)) bus ();

    genetic_fitness_eval #(
        .ROW    (2),
        .COL    (2),
        .IN     (2),
        .OUT    (1),
        .LOAD_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beats(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = data;
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    // Busy/done must stay low for n cycles.
    task automatic watch_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        check(tag, seen, 0);
    endtask

    task automatic run_eval(input logic [3:0] tgt, input int exp_fit,
                            input int exp_ff, input int exp_ffv, input bit hold_lv);
        int cyc;
        bus.target = tgt;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check("busy_on", bus.busy, 1);
        check("rdy_eval", bus.load_ready, 0);
        if (hold_lv) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'h00;
        end
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            tick();
            cyc++;
        end
        bus.load_valid = 1'b0;
        check("latency", cyc, 5);
        check("fitness", bus.fitness, exp_fit);
        check("busy_off", bus.busy, 0);
        check("rdy_done", bus.load_ready, 0);
`ifdef FIRST_FAIL_EN
        check("first_fail", bus.first_fail, exp_ff);
        check("first_fail_vld", bus.first_fail_vld, exp_ffv);
`else
        if (exp_ff < 0 || exp_ffv < 0) check("ff_args", 0, 1);
`endif
        tick();
        check("done_pulse", bus.done, 0);
        check("fit_hold", bus.fitness, exp_fit);
        check("rdy_idle", bus.load_ready, 1);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.target     = '0;
        bus.start      = 1'b0;
        repeat (3) tick();
        check("rst_ready", bus.load_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_fitness", bus.fitness, 0);
`ifdef FIRST_FAIL_EN
        check("rst_ff", bus.first_fail, 0);
        check("rst_ffv", bus.first_fail_vld, 0);
`endif
        rst = 1'b0;
        tick();

        // All-zero chromosome: every output is 0.
        load_beats(8'h00, 9);
        check("rdy_loaded", bus.load_ready, 1);
        run_eval(4'b0000, 4, 0, 0, 1'b0);
        // Same chromosome, vectors 1 and 3 expect 1.
        run_eval(4'b1010, 2, 1, 1, 1'b0);

        // All-ones chromosome: selector 3 picks a constant-1 cell.
        load_beats(8'hFF, 9);
        run_eval(4'b0000, 0, 0, 1, 1'b0);

        // Partial load: start must be ignored.
        load_beats(8'h00, 5);
        bus.target = 4'b0000;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        watch_quiet("partial_quiet", 8);
        check("partial_ready", bus.load_ready, 1);
        load_beats(8'h00, 4);
        run_eval(4'b1010, 2, 1, 1, 1'b0);

        // Reset two cycles into EVAL aborts without done.
        bus.target = 4'b0000;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_fitness", bus.fitness, 0);
        check("abort_done", bus.done, 0);
        watch_quiet("abort_quiet", 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        watch_quiet("unloaded_quiet", 8);

        // load_valid held through EVAL is ignored.
        load_beats(8'hFF, 9);
        run_eval(4'b1111, 4, 0, 0, 1'b1);
        run_eval(4'b1111, 4, 0, 0, 1'b0);
        run_eval(4'b0100, 1, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
